// File: rtl/mem_wb_master_pkg.sv
// Shared types and constants for the mem_wb_master block.
//   mem_size_e  : request access size (BYTE / HALF / WORD, 3 reserved)
//   mem_state_e : master FSM state encoding
//   TIMEOUT_CYCLES_DEFAULT : default bus-abort threshold (used only when
//                            MEM_WB_TIMEOUT_EN is defined)
//   is_misaligned() : request check done before any bus cycle is started
package mem_wb_master_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

  typedef enum logic [1:0] {
    BYTE      = 2'd0,
    HALF      = 2'd1,
    WORD      = 2'd2,
    SIZE_RSVD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Reserved size is treated like a misalignment: rejected without a bus cycle.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = addr_lo[0];
      2'd2:    is_misaligned = (addr_lo != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_master_lane_align.sv
// mem_wb_lane_align: purely combinational lane steering for mem_wb_master.
// Ports:
//   addr_lo     in  2   byte offset within the word
//   size        in  2   access size (mem_size_e)
//   is_unsigned in  1   zero-extend loads instead of sign-extend
//   wdata       in  32  right-aligned store data
//   rdata       in  32  raw Wishbone read word
//   sel         out 4   byte-lane enables
//   wdata_rep   out 32  store data replicated across lanes
//   rdata_ext   out 32  extracted and extended load data
module mem_wb_lane_align
  import mem_wb_master_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  always_comb begin
    // Move the addressed lane down to bit 0; word accesses have offset 0.
    shifted = rdata >> {addr_lo, 3'b000};
    sel       = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = shifted;
    case (size)
      BYTE: begin
        sel       = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'h0, shifted[7:0]}
                                : {{24{shifted[7]}}, shifted[7:0]};
      end
      HALF: begin
        sel       = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = is_unsigned ? {16'h0, shifted[15:0]}
                                : {{16{shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_master.sv
// mem_wb_master: turns single load/store requests into Wishbone classic
// cycles and returns a one-cycle response pulse.
// Optional feature: define MEM_WB_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT_CYCLES cycles without ack/err; otherwise the master waits forever.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   req_*                         request handshake (valid/ready) and fields
//   rsp_valid_o/rdata_o/err_o     response pulse, data, error flag
//   wb_cyc_o..wb_sel_o            Wishbone master outputs
//   wb_dat_i, wb_ack_i, wb_err_i  Wishbone slave return
//
// state   | meaning
// IDLE    | ready for a request
// BUS     | cyc/stb asserted, waiting for ack/err (or timeout)
// RESP    | one-cycle response pulse
module mem_wb_master
  import mem_wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  mem_state_e  state_q, state_d;
  logic        accept, reject, in_bus, term, tmo_hit;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        we_q, uns_q, err_q;
  mem_size_e   size_q;
  logic [3:0]  sel;
  logic [31:0] wdata_rep, rdata_ext;

  assign accept = req_valid_i & (state_q == ST_IDLE);
  assign reject = is_misaligned(req_size_i, req_addr_i[1:0]);
  assign in_bus = (state_q == ST_BUS);
  assign term   = in_bus & (wb_ack_i | wb_err_i);

`ifdef MEM_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;

  // Counter value equals the number of completed BUS cycles, so the
  // TIMEOUT_CYCLES-th BUS cycle is the last one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     tmo_cnt_q <= '0;
    else if (accept) tmo_cnt_q <= '0;
    else if (in_bus) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
  end

  assign tmo_hit = in_bus & ~term & (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
  // A zero threshold only matters when the timeout is built in.
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_unused
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = reject ? ST_RESP : ST_BUS;
      ST_BUS:  if (term || tmo_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= BYTE;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
      we_q    <= req_we_i;
      uns_q   <= req_unsigned_i;
      size_q  <= mem_size_e'(req_size_i);
      rdata_q <= '0;
      err_q   <= reject;
    end else if (term) begin
      // err wins over ack; stores and errors return zero data
      rdata_q <= (wb_err_i | we_q) ? 32'h0 : rdata_ext;
      err_q   <= wb_err_i;
    end else if (tmo_hit) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end
  end

  mem_wb_lane_align u_align (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rdata       (wb_dat_i),
    .sel         (sel),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  // Bus and response outputs are gated by state so everything idles at 0.
  always_comb begin
    req_ready_o = (state_q == ST_IDLE);
    wb_cyc_o    = in_bus;
    wb_stb_o    = in_bus;
    wb_we_o     = in_bus & we_q;
    wb_adr_o    = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
    wb_sel_o    = in_bus ? sel : 4'h0;
    wb_dat_o    = in_bus ? wdata_rep : 32'h0;
    rsp_valid_o = (state_q == ST_RESP);
    rsp_rdata_o = (state_q == ST_RESP) ? rdata_q : 32'h0;
    rsp_err_o   = (state_q == ST_RESP) & err_q;
  end

endmodule

// File: tb/tb_mem_wb_master.sv
// Directed bench for mem_wb_master. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
module tb_mem_wb_master;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [1:0]  req_size_i = '0;
  logic        req_unsigned_i = 1'b0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_wb_master #(.TIMEOUT_CYCLES(256)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  // Present a request at a falling edge, let the next rising edge accept it,
  // and return at the following falling edge.
  task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
    req_wdata_i = wdata; req_size_i = size; req_unsigned_i = uns;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  // Slave terminates in the current BUS cycle; returns at the RESP falling edge.
  task automatic slave_term(input logic ack, input logic err, input logic [31:0] data);
    wb_ack_i = ack; wb_err_i = err; wb_dat_i = data;
    @(posedge clk_i); #1;
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got cyc=%b stb=%b expected 0", wb_cyc_o, wb_stb_o); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp: got %b expected 0", rsp_valid_o); end
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
    checks++; if ({wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, rsp_rdata_o, rsp_err_o} !== '0) begin errors++; $display("FAIL reset_outputs: adr=%h dat=%h sel=%b expected all 0", wb_adr_o, wb_dat_o, wb_sel_o); end
  endtask

  task automatic test_word_load;
    send_req(1'b0, 32'h0200_BFF8, 32'h0, 2'd2, 1'b0);
    checks++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin errors++; $display("FAIL wl_cyc: got cyc=%b stb=%b expected 1", wb_cyc_o, wb_stb_o); end
    checks++; if (wb_sel_o !== 4'b1111) begin errors++; $display("FAIL wl_sel: got %b expected 1111", wb_sel_o); end
    checks++; if (wb_adr_o !== 32'h0200_BFF8) begin errors++; $display("FAIL wl_adr: got %h expected 0200bff8", wb_adr_o); end
    checks++; if (wb_we_o !== 1'b0 || req_ready_o !== 1'b0) begin errors++; $display("FAIL wl_we_ready: got we=%b ready=%b expected 0 0", wb_we_o, req_ready_o); end
    slave_term(1'b1, 1'b0, 32'h1234_5678);
    checks++; if (rsp_valid_o !== 1'b1 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL wl_rsp_timing: got rsp=%b cyc=%b expected 1 0", rsp_valid_o, wb_cyc_o); end
    checks++; if (rsp_rdata_o !== 32'h1234_5678 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL wl_data: got %h err=%b expected 12345678 err=0", rsp_rdata_o, rsp_err_o); end
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL wl_rsp_one_cycle: got rsp=%b ready=%b expected 0 1", rsp_valid_o, req_ready_o); end
  endtask

  task automatic test_byte_load;
    send_req(1'b0, 32'h0200_4003, 32'h0, 2'd0, 1'b0);
    checks++; if (wb_sel_o !== 4'b1000 || wb_adr_o !== 32'h0200_4000) begin errors++; $display("FAIL bl_sel_adr: got sel=%b adr=%h expected 1000 02004000", wb_sel_o, wb_adr_o); end
    slave_term(1'b1, 1'b0, 32'h80FF_0000);
    checks++; if (rsp_rdata_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL bl_signed: got %h expected ffffff80", rsp_rdata_o); end
    @(negedge clk_i);
    send_req(1'b0, 32'h0200_4003, 32'h0, 2'd0, 1'b1);
    slave_term(1'b1, 1'b0, 32'h80FF_0000);
    checks++; if (rsp_rdata_o !== 32'h0000_0080) begin errors++; $display("FAIL bl_unsigned: got %h expected 00000080", rsp_rdata_o); end
    @(negedge clk_i);
    send_req(1'b0, 32'h0200_4002, 32'h0, 2'd1, 1'b0);
    checks++; if (wb_sel_o !== 4'b1100) begin errors++; $display("FAIL hl_sel: got %b expected 1100", wb_sel_o); end
    slave_term(1'b1, 1'b0, 32'h8001_7777);
    checks++; if (rsp_rdata_o !== 32'hFFFF_8001) begin errors++; $display("FAIL hl_signed: got %h expected ffff8001", rsp_rdata_o); end
    @(negedge clk_i);
  endtask

  task automatic test_half_store;
    send_req(1'b1, 32'h0200_4002, 32'h0000_ABCD, 2'd1, 1'b0);
    checks++; if (wb_we_o !== 1'b1 || wb_sel_o !== 4'b1100) begin errors++; $display("FAIL hs_we_sel: got we=%b sel=%b expected 1 1100", wb_we_o, wb_sel_o); end
    checks++; if (wb_dat_o !== 32'hABCD_ABCD || wb_adr_o !== 32'h0200_4000) begin errors++; $display("FAIL hs_dat_adr: got dat=%h adr=%h expected abcdabcd 02004000", wb_dat_o, wb_adr_o); end
    @(negedge clk_i);
    checks++; if (wb_cyc_o !== 1'b1 || wb_dat_o !== 32'hABCD_ABCD || wb_sel_o !== 4'b1100) begin errors++; $display("FAIL hs_stable: got cyc=%b dat=%h sel=%b expected 1 abcdabcd 1100", wb_cyc_o, wb_dat_o, wb_sel_o); end
    slave_term(1'b1, 1'b0, 32'hDEAD_BEEF);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0 || rsp_err_o !== 1'b0) begin errors++; $display("FAIL hs_rsp: got v=%b d=%h e=%b expected 1 0 0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
    @(negedge clk_i);
    send_req(1'b1, 32'h0000_0005, 32'h0000_005A, 2'd0, 1'b0);
    checks++; if (wb_dat_o !== 32'h5A5A_5A5A || wb_sel_o !== 4'b0010) begin errors++; $display("FAIL bs_dat_sel: got dat=%h sel=%b expected 5a5a5a5a 0010", wb_dat_o, wb_sel_o); end
    slave_term(1'b1, 1'b0, 32'h0);
    @(negedge clk_i);
  endtask

  task automatic test_reject;
    logic [31:0] addrs [3] = '{32'h0200_4001, 32'h0200_4002, 32'h0200_4000};
    logic [1:0]  sizes [3] = '{2'd1, 2'd2, 2'd3};
    for (int i = 0; i < 3; i++) begin
      send_req(1'b0, addrs[i], 32'h0, sizes[i], 1'b0);
      checks++; if (wb_cyc_o !== 1'b0 || rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) begin errors++; $display("FAIL reject_%0d: got cyc=%b rsp=%b err=%b expected 0 1 1", i, wb_cyc_o, rsp_valid_o, rsp_err_o); end
      @(negedge clk_i);
      checks++; if (wb_cyc_o !== 1'b0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL reject_after_%0d: got cyc=%b rsp=%b ready=%b expected 0 0 1", i, wb_cyc_o, rsp_valid_o, req_ready_o); end
    end
  endtask

  task automatic test_bus_error;
    send_req(1'b0, 32'h0000_0010, 32'h0, 2'd2, 1'b0);
    slave_term(1'b1, 1'b1, 32'hFFFF_FFFF);
    checks++; if (rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL ack_err_both: got err=%b data=%h expected 1 0", rsp_err_o, rsp_rdata_o); end
    @(negedge clk_i);
    send_req(1'b0, 32'h0000_0010, 32'h0, 2'd2, 1'b0);
    slave_term(1'b0, 1'b1, 32'h1111_1111);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) begin errors++; $display("FAIL err_only: got rsp=%b err=%b expected 1 1", rsp_valid_o, rsp_err_o); end
    @(negedge clk_i);
    // Stray termination while idle must not create a response.
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL ack_idle_ignored: got rsp=%b ready=%b expected 0 1", rsp_valid_o, req_ready_o); end
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
  endtask

  task automatic test_timeout;
    int cyc_cnt = 0;
    send_req(1'b0, 32'h0000_0020, 32'h0, 2'd2, 1'b0);
`ifdef MEM_WB_TIMEOUT_EN
    for (int i = 0; i < 400; i++) begin
      if (wb_cyc_o !== 1'b1) break;
      cyc_cnt++;
      @(negedge clk_i);
    end
    checks++; if (cyc_cnt != 256) begin errors++; $display("FAIL tmo_cycles: got %0d bus cycles expected 256", cyc_cnt); end
    checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1) begin errors++; $display("FAIL tmo_rsp: got rsp=%b err=%b expected 1 1", rsp_valid_o, rsp_err_o); end
    @(negedge clk_i);
`else
    for (int i = 0; i < 300; i++) begin
      if (wb_cyc_o === 1'b1) cyc_cnt++;
      @(negedge clk_i);
    end
    checks++; if (cyc_cnt != 300 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL no_tmo_wait: got %0d cyc cycles rsp=%b expected 300 0", cyc_cnt, rsp_valid_o); end
    slave_term(1'b1, 1'b0, 32'hCAFE_F00D);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'hCAFE_F00D || rsp_err_o !== 1'b0) begin errors++; $display("FAIL no_tmo_late_ack: got v=%b d=%h e=%b expected 1 cafef00d 0", rsp_valid_o, rsp_rdata_o, rsp_err_o); end
    @(negedge clk_i);
`endif
  endtask

  task automatic test_reset_mid_bus;
    int rsp_seen = 0;
    send_req(1'b0, 32'h0000_0040, 32'h0, 2'd2, 1'b0);
    rst_ni = 1'b0;
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin errors++; $display("FAIL rst_mid_cyc: got cyc=%b stb=%b expected 0 0", wb_cyc_o, wb_stb_o); end
    wb_ack_i = 1'b1; wb_dat_i = 32'h5555_AAAA;
    @(negedge clk_i);
    rst_ni = 1'b1;
    wb_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid_o === 1'b1) rsp_seen++;
      @(negedge clk_i);
    end
    checks++; if (rsp_seen != 0) begin errors++; $display("FAIL rst_mid_no_rsp: got %0d pulses expected 0", rsp_seen); end
    send_req(1'b0, 32'h0000_0044, 32'h0, 2'd2, 1'b0);
    slave_term(1'b1, 1'b0, 32'h0BAD_F00D);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL rst_mid_recover: got v=%b d=%h expected 1 0badf00d", rsp_valid_o, rsp_rdata_o); end
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back;
    send_req(1'b0, 32'h0000_0100, 32'h0, 2'd2, 1'b0);
    wb_ack_i = 1'b1; wb_dat_i = 32'hA5A5_0001;
    @(posedge clk_i); #1;
    wb_ack_i = 1'b0;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h0000_0104;
    req_size_i = 2'd2; req_unsigned_i = 1'b0;
    @(negedge clk_i);
    checks++; if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0) begin errors++; $display("FAIL b2b_resp_not_ready: got rsp=%b ready=%b expected 1 0", rsp_valid_o, req_ready_o); end
    @(negedge clk_i);
    checks++; if (req_ready_o !== 1'b1 || wb_cyc_o !== 1'b0) begin errors++; $display("FAIL b2b_idle: got ready=%b cyc=%b expected 1 0", req_ready_o, wb_cyc_o); end
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    checks++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h0000_0104) begin errors++; $display("FAIL b2b_second: got cyc=%b adr=%h expected 1 00000104", wb_cyc_o, wb_adr_o); end
    slave_term(1'b1, 1'b0, 32'hA5A5_0002);
    checks++; if (rsp_rdata_o !== 32'hA5A5_0002) begin errors++; $display("FAIL b2b_data: got %h expected a5a50002", rsp_rdata_o); end
    @(negedge clk_i);
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_reject();
    test_bus_error();
    test_timeout();
    test_reset_mid_bus();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_master.md
MEM_WB_MASTER -- requirements
Module: mem_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: bus cycles without ack/err before abort.
REQ-002 SHALL have ports:
- clk_i  in  1  sole clock
- rst_ni  in  1  asynchronous reset, active-low
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_we_i  in  1  1 = store, 0 = load
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned_i  in  1  zero-extend load data
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  32  extended load data, 0 for stores
- rsp_err_o  out  1  misaligned, size 3, bus error or timeout
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone classic master controls
- wb_adr_o  out  32  word-aligned address
- wb_dat_o  out  32  write data
- wb_sel_o  out  4  byte lanes
- wb_dat_i  in  32  read data
- wb_ack_i, wb_err_i  in  1  slave termination

Function
REQ-003 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; IDLE -> RESP directly on a rejected request.
REQ-004 req_ready_o SHALL be 1 only in IDLE; accept = req_valid_i & req_ready_o; all request fields are registered on accept.
REQ-005 Reject: half with addr[0]=1, word with addr[1:0]!=0, or size 3 -> no bus cycle; RESP with rsp_err_o=1.
REQ-006 BUS: wb_cyc_o=wb_stb_o=1 from the cycle after accept until the termination cycle inclusive; adr/we/sel/dat stable throughout.
REQ-007 wb_adr_o = {addr[31:2],2'b00}; wb_sel_o: byte 4'b0001<<addr[1:0], half 4'b0011<<addr[1:0], word 4'b1111.
REQ-008 wb_dat_o SHALL replicate the byte (x4) or half (x2) across lanes; word passes through.
REQ-009 Termination = wb_ack_i|wb_err_i while in BUS; wb_err_i wins if both are high; ack/err outside BUS is ignored.
REQ-010 On termination, cyc/stb SHALL drop in the next cycle (RESP); load data is captured from wb_dat_i in the termination cycle.
REQ-011 Load extraction: lane selected by addr[1:0]; sign-extend unless req_unsigned_i; on error rsp_rdata_o=0.
REQ-012 RESP lasts exactly one cycle: rsp_valid_o=1 with data/err; next state IDLE. No response backpressure.
REQ-013 Latency: accept at N -> stb at N+1 -> ack at earliest N+1 -> rsp_valid_o at ack+1; back-to-back accept at earliest rsp+1.

Reset
REQ-014 rst_ni low SHALL asynchronously force IDLE, timeout counter 0, and all outputs 0 except req_ready_o=1 after release.
REQ-015 Reset during BUS SHALL drop cyc/stb immediately with no response issued.

Configuration
REQ-016 With MEM_WB_TIMEOUT_EN defined: a counter cleared on entering BUS increments each BUS cycle; when it reaches TIMEOUT_CYCLES without termination, enter RESP with rsp_err_o=1 and drop cyc/stb.
REQ-017 Without MEM_WB_TIMEOUT_EN: no counter is instantiated; BUS waits indefinitely.

Structure
REQ-018 Shared package SHALL hold the mem_size_e typedef (BYTE/HALF/WORD), the FSM state enum, and the TIMEOUT_CYCLES default constant.
REQ-019 One sub-module, mem_wb_lane_align (combinational sel/wdata replication and load extraction), SHALL be instantiated; the FSM stays in mem_wb_master.

Verification
REQ-020 Word load 0x0200BFF8, slave acks one cycle after stb with 0x12345678 -> sel 4'b1111, adr 0x0200BFF8, rsp_rdata_o 0x12345678, err 0, rsp at ack+1.
REQ-021 Signed byte load 0x02004003, wb_dat_i 0x80FF0000 -> sel 4'b1000, rsp_rdata_o 0xFFFFFF80; unsigned -> 0x00000080.
REQ-022 Half store 0x02004002, wdata 0x0000ABCD -> wb_we_o 1, sel 4'b1100, wb_dat_o 0xABCDABCD, adr 0x02004000.
REQ-023 Half load 0x02004001 -> no cyc/stb ever, rsp_valid_o pulse with err 1 on the cycle after accept.
REQ-024 With MEM_WB_TIMEOUT_EN and TIMEOUT_CYCLES=256, no slave response -> cyc drops after 256 BUS cycles, rsp err 1; ack+err in same cycle -> err 1.
REQ-025 rst_ni pulsed low mid-BUS -> cyc/stb 0 immediately, no rsp_valid_o; next request completes normally.
